// File: rtl/block_grid_pkg.sv
// Shared types and helpers for the brick-state store.
// The level patterns are defined here so that the reset image and the loader agree.
package block_grid_pkg;

  localparam int MAX_COLS = 64;

  typedef enum logic [1:0] {
    PAT_STAIR   = 2'd0,
    PAT_FULL    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_EMPTY   = 2'd3
  } pattern_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  // Rows 0 and 1 are kept empty in every pattern to leave headroom under the top wall.
  function automatic logic [MAX_COLS-1:0] pattern_row(input pattern_t pattern, input int r,
                                                      input int ncols);
    logic [MAX_COLS-1:0] bits;
    bits = '0;
    for (int c = 0; c < MAX_COLS; c++) begin
      if (r >= 2 && c < ncols) begin
        case (pattern)
          PAT_STAIR:   bits[c] = (c < r - 1);
          PAT_FULL:    bits[c] = 1'b1;
          PAT_CHECKER: bits[c] = (((r + c) % 2) == 1);
          default:     bits[c] = 1'b0;
        endcase
      end
    end
    return bits;
  endfunction

  function automatic int popcount(input logic [MAX_COLS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_COLS; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  function automatic int pattern_total(input pattern_t pattern, input int nrows, input int ncols);
    int total;
    total = 0;
    for (int r = 0; r < nrows; r++) begin
      total += popcount(pattern_row(pattern, r, ncols));
    end
    return total;
  endfunction

endpackage

// File: rtl/block_grid_if.sv
// Bus between the brick store, the collision unit and the row renderer.
interface block_grid_if #(
  parameter int NUM_ROWS = 15,
  parameter int NUM_COLS = 13
);
  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int COL_W = $clog2(NUM_COLS);
  localparam int CNT_W = $clog2(NUM_ROWS * NUM_COLS + 1);

  logic [NUM_COLS-1:0] line;
  logic [ROW_W-1:0]    line_row;
  logic                next_line;
  logic                write_line;
  logic [NUM_COLS-1:0] new_line;
  logic                hit_valid;
  logic [ROW_W-1:0]    hit_row;
  logic [COL_W-1:0]    hit_col;
  logic                hit_ready;
  logic                hit_done;
  logic                hit_was_set;
  logic                load_start;
  logic [1:0]          load_pattern;
  logic                busy;
  logic [CNT_W-1:0]    blocks_left;
  logic                cleared;

  modport master (
    input  line, line_row, hit_ready, hit_done, hit_was_set, busy, blocks_left, cleared,
    output next_line, write_line, new_line, hit_valid, hit_row, hit_col, load_start, load_pattern
  );

  modport slave (
    output line, line_row, hit_ready, hit_done, hit_was_set, busy, blocks_left, cleared,
    input  next_line, write_line, new_line, hit_valid, hit_row, hit_col, load_start, load_pattern
  );

endinterface

// File: rtl/block_grid_pattern_gen.sv
// Combinational level-pattern source: one row of bricks and its brick count.
module block_grid_pattern_gen
  import block_grid_pkg::*;
#(
  parameter int NUM_ROWS = 15,
  parameter int NUM_COLS = 13,
  localparam int ROW_W = $clog2(NUM_ROWS),
  localparam int CNT_W = $clog2(NUM_ROWS * NUM_COLS + 1)
) (
  input  pattern_t            pattern,
  input  logic [ROW_W-1:0]    row,
  output logic [NUM_COLS-1:0] bits,
  output logic [CNT_W-1:0]    count
);

  logic [MAX_COLS-1:0] full_bits;

  always_comb begin
    full_bits = pattern_row(pattern, int'(row), NUM_COLS);
    bits      = full_bits[NUM_COLS-1:0];
    count     = CNT_W'(popcount(full_bits));
  end

endmodule

// File: rtl/block_grid.sv
// Brick-state store: row-scan readout for the renderer, addressed hit clear,
// live-brick counter and a one-row-per-cycle level loader.
module block_grid
  import block_grid_pkg::*;
#(
  parameter int NUM_ROWS = 15,
  parameter int NUM_COLS = 13
) (
  input logic         clk,
  input logic         nRst,
  block_grid_if.slave bus
);

  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int CNT_W = $clog2(NUM_ROWS * NUM_COLS + 1);
  localparam logic [CNT_W-1:0] STAIR_TOTAL = CNT_W'(pattern_total(PAT_STAIR, NUM_ROWS, NUM_COLS));
  localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(NUM_ROWS - 1);

  state_t              state_q, state_d;
  pattern_t            pattern_q;
  logic [ROW_W-1:0]    load_row_q;
  logic [ROW_W-1:0]    scan_q;
  logic [NUM_COLS-1:0] rows_q [NUM_ROWS];
  logic [CNT_W-1:0]    blocks_q;
  logic                hit_done_q;
  logic                hit_was_set_q;

  logic                idle;
  logic                hit_accept;
  logic                hit_in_range;
  logic                hit_old;
  logic                hit_clear;
  logic                write_en;
  logic [NUM_COLS-1:0] cur_row;
  logic [NUM_COLS-1:0] gen_bits;
  logic [CNT_W-1:0]    gen_count;
  logic [CNT_W-1:0]    write_delta;
  logic [CNT_W-1:0]    hit_dec;

  block_grid_pattern_gen #(
    .NUM_ROWS (NUM_ROWS),
    .NUM_COLS (NUM_COLS)
  ) u_pattern_gen (
    .pattern (pattern_q),
    .row     (load_row_q),
    .bits    (gen_bits),
    .count   (gen_count)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.load_start) state_d = ST_LOAD;
      ST_LOAD: if (load_row_q == LAST_ROW) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idle          = (state_q == ST_IDLE);
    bus.busy      = (state_q == ST_LOAD);
    bus.hit_ready = idle & ~bus.load_start;
  end

  // A write to the hit's row takes the whole row, so the hit's clear and decrement are dropped.
  always_comb begin
    cur_row      = rows_q[scan_q];
    hit_accept   = bus.hit_valid & bus.hit_ready;
    hit_in_range = (int'(bus.hit_row) < NUM_ROWS) && (int'(bus.hit_col) < NUM_COLS);
    hit_old      = hit_in_range ? rows_q[bus.hit_row][bus.hit_col] : 1'b0;
    write_en     = idle & ~bus.load_start & bus.write_line;
    hit_clear    = hit_accept & hit_in_range & ~(write_en && (bus.hit_row == scan_q));
    write_delta  = write_en ? CNT_W'(popcount(MAX_COLS'(bus.new_line)))
                              - CNT_W'(popcount(MAX_COLS'(cur_row)))
                            : '0;
    hit_dec      = (hit_clear && hit_old) ? CNT_W'(1) : '0;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        rows_q[r] <= NUM_COLS'(pattern_row(PAT_STAIR, r, NUM_COLS));
      end
      scan_q        <= '0;
      load_row_q    <= '0;
      pattern_q     <= PAT_STAIR;
      blocks_q      <= STAIR_TOTAL;
      hit_done_q    <= 1'b0;
      hit_was_set_q <= 1'b0;
    end else begin
      hit_done_q    <= hit_accept;
      hit_was_set_q <= hit_accept & hit_old;
      if (state_q == ST_LOAD) begin
        rows_q[load_row_q] <= gen_bits;
        blocks_q           <= blocks_q + gen_count;
        load_row_q         <= load_row_q + 1'b1;
        if (load_row_q == LAST_ROW) scan_q <= '0;
      end else if (bus.load_start) begin
        pattern_q  <= pattern_t'(bus.load_pattern);
        blocks_q   <= '0;
        load_row_q <= '0;
      end else begin
        if (hit_clear) rows_q[bus.hit_row][bus.hit_col] <= 1'b0;
        if (write_en)  rows_q[scan_q] <= bus.new_line;
        blocks_q <= blocks_q + write_delta - hit_dec;
        if (bus.next_line) scan_q <= (scan_q == LAST_ROW) ? '0 : scan_q + 1'b1;
      end
    end
  end

  assign bus.line        = cur_row;
  assign bus.line_row    = scan_q;
  assign bus.hit_done    = hit_done_q;
  assign bus.hit_was_set = hit_was_set_q;
  assign bus.blocks_left = blocks_q;
  assign bus.cleared     = (blocks_q == '0) & ~bus.busy;

endmodule

// File: tb/tb_block_grid.sv
// Bench for block_grid: directed vector table, load sequences and random traffic,
// all compared against a bit-per-brick model of the grid.
module tb_block_grid;

  localparam int NUM_ROWS = 15;
  localparam int NUM_COLS = 13;

  typedef struct {
    bit                  nl;
    bit                  wl;
    logic [NUM_COLS-1:0] nline;
    bit                  hv;
    logic [3:0]          hr;
    logic [3:0]          hc;
    bit                  ls;
    logic [1:0]          pat;
  } stim_t;

  typedef struct {
    string               name;
    stim_t               s;
    int                  reps;
    logic [NUM_COLS-1:0] e_line;
    int                  e_row;
    int                  e_blocks;
    bit                  e_done;
    bit                  e_was;
  } vec_t;

  logic clk = 1'b0;
  logic nRst;
  int   vec_count   = 0;
  int   miscompares = 0;

  bit   grid [NUM_ROWS][NUM_COLS];
  int   m_scan;
  int   m_remaining;
  int   m_pattern;
  bit   m_done;
  bit   m_was;
  vec_t vecs[$];

  block_grid_if #(.NUM_ROWS(NUM_ROWS), .NUM_COLS(NUM_COLS)) bus ();

  block_grid #(.NUM_ROWS(NUM_ROWS), .NUM_COLS(NUM_COLS)) u_dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic bit patternBit(int p, int r, int c);
    int stair_len;
    if (r < 2) return 1'b0;
    stair_len = (r - 1 < NUM_COLS) ? r - 1 : NUM_COLS;
    case (p)
      0:       return c < stair_len;
      1:       return 1'b1;
      2:       return ((r + c) % 2) == 1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void modelFill(int p);
    for (int r = 0; r < NUM_ROWS; r++)
      for (int c = 0; c < NUM_COLS; c++)
        grid[r][c] = patternBit(p, r, c);
  endfunction

  function automatic int modelCount();
    int n = 0;
    for (int r = 0; r < NUM_ROWS; r++)
      for (int c = 0; c < NUM_COLS; c++)
        n += int'(grid[r][c]);
    return n;
  endfunction

  function automatic logic [NUM_COLS-1:0] modelLine();
    logic [NUM_COLS-1:0] v;
    for (int c = 0; c < NUM_COLS; c++) v[c] = grid[m_scan][c];
    return v;
  endfunction

  function automatic void modelReset();
    modelFill(0);
    m_scan      = 0;
    m_remaining = 0;
    m_done      = 1'b0;
    m_was       = 1'b0;
  endfunction

  // A level load is modelled as NUM_ROWS busy cycles followed by the whole pattern appearing at once.
  function automatic void modelStep(stim_t s);
    bit inr;
    m_done = 1'b0;
    m_was  = 1'b0;
    if (m_remaining > 0) begin
      m_remaining--;
      if (m_remaining == 0) begin
        modelFill(m_pattern);
        m_scan = 0;
      end
    end else begin
      inr = (int'(s.hr) < NUM_ROWS) && (int'(s.hc) < NUM_COLS);
      if (s.hv && !s.ls) begin
        m_done = 1'b1;
        m_was  = inr ? grid[int'(s.hr)][int'(s.hc)] : 1'b0;
      end
      if (s.ls) begin
        m_pattern   = int'(s.pat);
        m_remaining = NUM_ROWS;
      end else begin
        if (s.hv && inr) grid[int'(s.hr)][int'(s.hc)] = 1'b0;
        if (s.wl) for (int c = 0; c < NUM_COLS; c++) grid[m_scan][c] = s.nline[c];
        if (s.nl) m_scan = (m_scan + 1) % NUM_ROWS;
      end
    end
  endfunction

  function automatic stim_t idleStim();
    stim_t s;
    s.nl = 1'b0; s.wl = 1'b0; s.nline = '0; s.hv = 1'b0;
    s.hr = '0; s.hc = '0; s.ls = 1'b0; s.pat = '0;
    return s;
  endfunction

  function automatic stim_t mkStim(bit nl, bit wl, logic [NUM_COLS-1:0] nline, bit hv, int hr, int hc);
    stim_t s = idleStim();
    s.nl = nl; s.wl = wl; s.nline = nline; s.hv = hv; s.hr = 4'(hr); s.hc = 4'(hc);
    return s;
  endfunction

  task automatic addVec(string name, stim_t s, int reps, logic [NUM_COLS-1:0] e_line, int e_row,
                        int e_blocks, bit e_done, bit e_was);
    vec_t v;
    v.name = name; v.s = s; v.reps = reps; v.e_line = e_line; v.e_row = e_row;
    v.e_blocks = e_blocks; v.e_done = e_done; v.e_was = e_was;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkModel();
    checkOutput("busy", 32'(bus.busy), 32'(m_remaining > 0));
    checkOutput("hit_done", 32'(bus.hit_done), 32'(m_done));
    checkOutput("hit_was_set", 32'(bus.hit_was_set), 32'(m_was));
    if (m_remaining == 0) begin
      checkOutput("line", 32'(bus.line), 32'(modelLine()));
      checkOutput("line_row", 32'(bus.line_row), 32'(m_scan));
      checkOutput("blocks_left", 32'(bus.blocks_left), 32'(modelCount()));
      checkOutput("cleared", 32'(bus.cleared), 32'(modelCount() == 0));
    end else begin
      checkOutput("cleared_busy", 32'(bus.cleared), 32'(0));
    end
  endtask

  // Drive one cycle of inputs just after a rising edge; outputs are checked 1ns after the next one.
  task automatic applyStimulus(stim_t s);
    bus.next_line    = s.nl;
    bus.write_line   = s.wl;
    bus.new_line     = s.nline;
    bus.hit_valid    = s.hv;
    bus.hit_row      = s.hr;
    bus.hit_col      = s.hc;
    bus.load_start   = s.ls;
    bus.load_pattern = s.pat;
    #1;
    checkOutput("hit_ready", 32'(bus.hit_ready), 32'((m_remaining == 0) && !s.ls));
    @(posedge clk);
    modelStep(s);
    #1;
    checkModel();
  endtask

  task automatic runLoad(int pat, int e_total, string name);
    stim_t s;
    stim_t s_busy;
    int    busy_cycles = 0;
    int    ready_seen  = 0;
    s = mkStim(1'b0, 1'b0, '0, 1'b1, 14, 12);
    s.ls  = 1'b1;
    s.pat = 2'(pat);
    applyStimulus(s);
    s_busy = mkStim(1'b1, 1'b1, 13'h0AAA, 1'b1, 3, 2);
    s_busy.ls  = 1'b1;
    s_busy.pat = 2'd3;
    for (int k = 0; k < 40 && bus.busy; k++) begin
      busy_cycles++;
      if (bus.hit_ready) ready_seen++;
      applyStimulus(s_busy);
    end
    checkOutput({name, ".busy_cycles"}, 32'(busy_cycles), 32'(NUM_ROWS));
    checkOutput({name, ".ready_in_load"}, 32'(ready_seen), 32'(0));
    checkOutput({name, ".blocks_left"}, 32'(bus.blocks_left), 32'(e_total));
    checkOutput({name, ".line_row"}, 32'(bus.line_row), 32'(0));
    checkOutput({name, ".cleared"}, 32'(bus.cleared), 32'(e_total == 0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    stim_t s;
    nRst = 1'b0;
    bus.next_line = 1'b0; bus.write_line = 1'b0; bus.new_line = '0; bus.hit_valid = 1'b0;
    bus.hit_row = '0; bus.hit_col = '0; bus.load_start = 1'b0; bus.load_pattern = '0;
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    nRst = 1'b1;

    checkOutput("reset.blocks_left", 32'(bus.blocks_left), 32'd91);
    checkOutput("reset.line", 32'(bus.line), 32'd0);
    checkOutput("reset.line_row", 32'(bus.line_row), 32'd0);
    checkOutput("reset.busy", 32'(bus.busy), 32'd0);
    checkOutput("reset.hit_done", 32'(bus.hit_done), 32'd0);
    checkOutput("reset.hit_was_set", 32'(bus.hit_was_set), 32'd0);
    checkOutput("reset.cleared", 32'(bus.cleared), 32'd0);
    checkOutput("reset.hit_ready", 32'(bus.hit_ready), 32'd1);

    addVec("scan1",         mkStim(1, 0, '0, 0, 0, 0),        1,  13'h0000,  1, 91, 0, 0);
    addVec("scan14",        mkStim(1, 0, '0, 0, 0, 0),        13, 13'h1FFF, 14, 91, 0, 0);
    addVec("hit14_0",       mkStim(0, 0, '0, 1, 14, 0),       1,  13'h1FFE, 14, 90, 1, 1);
    addVec("hit14_0_again", mkStim(0, 0, '0, 1, 14, 0),       1,  13'h1FFE, 14, 90, 1, 0);
    addVec("hit_row15",     mkStim(0, 0, '0, 1, 15, 3),       1,  13'h1FFE, 14, 90, 1, 0);
    addVec("hit_col13",     mkStim(0, 0, '0, 1, 5, 13),       1,  13'h1FFE, 14, 90, 1, 0);
    addVec("wrap",          mkStim(1, 0, '0, 0, 0, 0),        1,  13'h0000,  0, 90, 0, 0);
    addVec("scan5",         mkStim(1, 0, '0, 0, 0, 0),        5,  13'h000F,  5, 90, 0, 0);
    addVec("write_hit5",    mkStim(0, 1, 13'h1FFF, 1, 5, 0),  1,  13'h1FFF,  5, 99, 1, 1);
    addVec("quiet",         mkStim(0, 0, '0, 0, 0, 0),        1,  13'h1FFF,  5, 99, 0, 0);

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].reps; k++) applyStimulus(vecs[i].s);
      checkOutput({vecs[i].name, ".line"}, 32'(bus.line), 32'(vecs[i].e_line));
      checkOutput({vecs[i].name, ".line_row"}, 32'(bus.line_row), 32'(vecs[i].e_row));
      checkOutput({vecs[i].name, ".blocks_left"}, 32'(bus.blocks_left), 32'(vecs[i].e_blocks));
      checkOutput({vecs[i].name, ".hit_done"}, 32'(bus.hit_done), 32'(vecs[i].e_done));
      checkOutput({vecs[i].name, ".hit_was_set"}, 32'(bus.hit_was_set), 32'(vecs[i].e_was));
    end

    runLoad(1, 169, "load_full");
    runLoad(2, 84, "load_checker");
    runLoad(3, 0, "load_empty");

    s = idleStim();
    s.ls  = 1'b1;
    s.pat = 2'd1;
    applyStimulus(s);
    for (int k = 0; k < 5; k++) applyStimulus(idleStim());
    nRst = 1'b0;
    modelReset();
    #1;
    checkOutput("abort.busy", 32'(bus.busy), 32'd0);
    checkOutput("abort.blocks_left", 32'(bus.blocks_left), 32'd91);
    checkOutput("abort.line_row", 32'(bus.line_row), 32'd0);
    @(posedge clk);
    #1;
    nRst = 1'b1;
    for (int k = 0; k < 5; k++) applyStimulus(mkStim(1, 0, '0, 0, 0, 0));
    checkOutput("abort.row5_line", 32'(bus.line), 32'h000F);

    for (int n = 0; n < 400; n++) begin
      s.nl    = ($urandom_range(0, 9) < 3);
      s.wl    = ($urandom_range(0, 9) == 0);
      s.nline = 13'($urandom);
      s.hv    = ($urandom_range(0, 1) == 1);
      s.hr    = ($urandom_range(0, 3) == 0) ? 4'(m_scan) : 4'($urandom_range(0, 15));
      s.hc    = 4'($urandom_range(0, 15));
      s.ls    = ($urandom_range(0, 49) == 0);
      s.pat   = 2'($urandom_range(0, 3));
      applyStimulus(s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
